// File: rtl/slave_stream_s00_axis.sv
`default_nettype none
// ============================================================================
// Module      : slave_stream_s00_axis
// Description : AXI4-Stream slave feeding a FIFO write port through a
//               two-entry skid buffer with registered TREADY. Optional TLAST
//               path enabled by SLAVE_STREAM_TLAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_stream_s00_axis #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_BEAT_CNT_WIDTH     = 32,
  parameter int C_PKT_CNT_WIDTH      = 16
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic                            S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic                            fifo_wr_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_wr_data,
  output logic                            fifo_wr_last,
  input  logic                            fifo_full,
  output logic [C_BEAT_CNT_WIDTH-1:0]     beat_count,
  output logic [C_PKT_CNT_WIDTH-1:0]      pkt_count
);

  localparam logic [2:0] c_EMPTY = 3'b001;
  localparam logic [2:0] c_ONE   = 3'b010;
  localparam logic [2:0] c_FULL  = 3'b100;

  localparam logic [C_BEAT_CNT_WIDTH-1:0] c_BEAT_ONE = {{(C_BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]                      r_state;
  logic [2:0]                      w_next;
  logic                            r_tready;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] r_out_data;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] r_skid_data;
  logic [C_BEAT_CNT_WIDTH-1:0]     r_beat_cnt;

  logic w_acc;
  logic w_wr_en;
  logic w_wr;
  logic w_load_out_in;
  logic w_load_out_skid;
  logic w_load_skid;

  assign w_acc   = S_AXIS_TVALID & r_tready;
  assign w_wr_en = (r_state == c_ONE) || (r_state == c_FULL);
  assign w_wr    = w_wr_en & ~fifo_full;

  always_comb begin
    w_next          = c_EMPTY;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      c_EMPTY: begin
        if (w_acc) begin
          w_next        = c_ONE;
          w_load_out_in = 1'b1;
        end else begin
          w_next = c_EMPTY;
        end
      end
      c_ONE: begin
        if (w_acc && w_wr) begin
          w_next        = c_ONE;
          w_load_out_in = 1'b1;
        end else if (w_acc) begin
          w_next      = c_FULL;
          w_load_skid = 1'b1;
        end else if (w_wr) begin
          w_next = c_EMPTY;
        end else begin
          w_next = c_ONE;
        end
      end
      c_FULL: begin
        // TREADY is low here, so only the drain of out can happen.
        if (w_wr) begin
          w_next          = c_ONE;
          w_load_out_skid = 1'b1;
        end else begin
          w_next = c_FULL;
        end
      end
      default: w_next = c_EMPTY;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_state     <= c_EMPTY;
      r_tready    <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_state  <= w_next;
      r_tready <= (w_next != c_FULL);
      if (w_load_out_in) begin
        r_out_data <= S_AXIS_TDATA;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= S_AXIS_TDATA;
      end
      if (w_acc) begin
        r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
      end
    end
  end

  assign S_AXIS_TREADY = r_tready;
  assign fifo_wr_en    = w_wr_en;
  assign fifo_wr_data  = r_out_data;
  assign beat_count    = r_beat_cnt;

`ifdef SLAVE_STREAM_TLAST_EN
  localparam logic [C_PKT_CNT_WIDTH-1:0] c_PKT_ONE = {{(C_PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                       r_out_last;
  logic                       r_skid_last;
  logic [C_PKT_CNT_WIDTH-1:0] r_pkt_cnt;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      r_out_last  <= 1'b0;
      r_skid_last <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out_last <= S_AXIS_TLAST;
      end else if (w_load_out_skid) begin
        r_out_last <= r_skid_last;
      end
      if (w_load_skid) begin
        r_skid_last <= S_AXIS_TLAST;
      end
      if (w_acc && S_AXIS_TLAST) begin
        r_pkt_cnt <= r_pkt_cnt + c_PKT_ONE;
      end
    end
  end

  assign fifo_wr_last = r_out_last;
  assign pkt_count    = r_pkt_cnt;
`else
  logic w_unused_tlast;

  assign w_unused_tlast = S_AXIS_TLAST;
  assign fifo_wr_last   = 1'b0;
  assign pkt_count      = '0;
`endif

endmodule
`default_nettype wire
